// File: rtl/fixed_point_requantizer.sv
// Multi-lane pipelined requantizer: round-half-up right shift, then saturate/wrap/ReLU per lane.
// Three stages (capture, round/shift, clamp) share one advance enable for full backpressure.
module fixed_point_requantizer #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int LANES       = 4,
  parameter int SHIFT_WIDTH = $clog2(IN_WIDTH),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [LANES*IN_WIDTH-1:0]      s_data_in,
  input  logic [SHIFT_WIDTH-1:0]         s_shift_in,
  input  logic [1:0]                     s_mode_in,
  input  logic                           s_valid_in,
  output logic                           s_ready_out,
  output logic [LANES*OUT_WIDTH-1:0]     m_data_out,
  output logic [LANES-1:0]               m_sat_flags_out,
  output logic                           m_valid_out,
  input  logic                           m_ready_in,
  output logic [CNT_WIDTH-1:0]           sat_count_out,
  input  logic                           sat_count_clear_in
);

  localparam int YW = IN_WIDTH + 1;
  localparam int PW = $clog2(LANES + 1);

  localparam logic signed [YW-1:0] MAX_V =
    signed'({{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [YW-1:0] MIN_V =
    signed'({{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});
  localparam logic [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                           adv;
  logic [LANES*IN_WIDTH-1:0]      d1_q;
  logic [SHIFT_WIDTH-1:0]         sh1_q;
  logic [1:0]                     md1_q;
  logic                           v1_q;
  logic [LANES*YW-1:0]            y2_q, y2_d;
  logic [1:0]                     md2_q;
  logic                           v2_q;
  logic [LANES*OUT_WIDTH-1:0]     out_q, out_d;
  logic [LANES-1:0]               flg_q, flg_d;
  logic                           v3_q;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]                  pop;
  logic [CNT_WIDTH:0]             cnt_sum;

  assign adv         = !v3_q || m_ready_in;
  assign s_ready_out = adv;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [YW-1:0]  x, r, y, yq;
      logic [OUT_WIDTH-1:0]  o;
      logic                  f;

      // The extra top bit keeps x + r from overflowing at the positive extreme.
      assign x = signed'({d1_q[gi*IN_WIDTH+IN_WIDTH-1], d1_q[gi*IN_WIDTH +: IN_WIDTH]});
      assign r = (sh1_q == '0) ? '0 : signed'(YW'(1) << (sh1_q - SHIFT_WIDTH'(1)));
      assign y = (x + r) >>> sh1_q;
      assign y2_d[gi*YW +: YW] = y;

      assign yq = signed'(y2_q[gi*YW +: YW]);
      always_comb begin
        o = yq[OUT_WIDTH-1:0];
        f = 1'b0;
        case (md2_q)
          2'b01: ;
          2'b10: begin
            if (yq[YW-1]) begin
              o = '0;
              f = 1'b1;
            end else if (yq > MAX_V) begin
              o = MAX_O;
              f = 1'b1;
            end
          end
          default: begin
            if (yq > MAX_V) begin
              o = MAX_O;
              f = 1'b1;
            end else if (yq < MIN_V) begin
              o = MIN_O;
              f = 1'b1;
            end
          end
        endcase
      end
      assign out_d[gi*OUT_WIDTH +: OUT_WIDTH] = o;
      assign flg_d[gi] = f;
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PW'(flg_d[i]);
    end
  end

  // Clear wins over a same-cycle increment; the sum's carry bit signals saturation.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(pop);
  always_comb begin
    cnt_d = cnt_q;
    if (sat_count_clear_in) begin
      cnt_d = '0;
    end else if (adv && v2_q) begin
      cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      d1_q  <= '0;
      sh1_q <= '0;
      md1_q <= '0;
      v1_q  <= 1'b0;
      y2_q  <= '0;
      md2_q <= '0;
      v2_q  <= 1'b0;
      out_q <= '0;
      flg_q <= '0;
      v3_q  <= 1'b0;
    end else if (adv) begin
      d1_q  <= s_data_in;
      sh1_q <= s_shift_in;
      md1_q <= s_mode_in;
      v1_q  <= s_valid_in;
      y2_q  <= y2_d;
      md2_q <= md1_q;
      v2_q  <= v1_q;
      out_q <= out_d;
      flg_q <= flg_d;
      v3_q  <= v2_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m_data_out      = out_q;
  assign m_sat_flags_out = flg_q;
  assign m_valid_out     = v3_q;
  assign sat_count_out   = cnt_q;

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Directed bench for fixed_point_requantizer: 4 lanes, 32-bit in, 16-bit out.
module tb_fixed_point_requantizer;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [127:0]  s_data_in;
  logic [4:0]    s_shift_in;
  logic [1:0]    s_mode_in;
  logic          s_valid_in;
  logic          s_ready_out;
  logic [63:0]   m_data_out;
  logic [3:0]    m_sat_flags_out;
  logic          m_valid_out;
  logic          m_ready_in;
  logic [15:0]   sat_count_out;
  logic          sat_count_clear_in;

  int vectors = 0;
  int errors  = 0;

  fixed_point_requantizer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_data_in(s_data_in), .s_shift_in(s_shift_in), .s_mode_in(s_mode_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .m_data_out(m_data_out), .m_sat_flags_out(m_sat_flags_out),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
    .sat_count_out(sat_count_out), .sat_count_clear_in(sat_count_clear_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] pin(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] pout(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [4:0] sh, input logic [1:0] md);
    s_data_in  = d;
    s_shift_in = sh;
    s_mode_in  = md;
    s_valid_in = 1'b1;
    step();
    s_valid_in = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d, input logic [3:0] f,
                            input logic [15:0] cnt);
    chk({tag, "_valid"}, 64'(m_valid_out), 64'd1);
    chk({tag, "_data"},  m_data_out, d);
    chk({tag, "_flags"}, 64'(m_sat_flags_out), 64'(f));
    chk({tag, "_count"}, 64'(sat_count_out), 64'(cnt));
  endtask

  logic [127:0] bp_in [6];
  logic [4:0]   bp_sh [6];
  logic [1:0]   bp_md [6];
  logic [63:0]  bp_d  [6];
  logic [3:0]   bp_f  [6];
  int           sent, rcv;

  initial begin
    rst_in = 1'b1; s_data_in = '0; s_shift_in = '0; s_mode_in = '0; s_valid_in = 1'b0;
    m_ready_in = 1'b1; sat_count_clear_in = 1'b0;

    bp_in[0] = pin(100, -100, 40000, 7);            bp_sh[0] = 5'd0; bp_md[0] = 2'b00;
    bp_d[0]  = pout(16'h0064, 16'hff9c, 16'h7fff, 16'h0007); bp_f[0] = 4'b0100;
    bp_in[1] = pin(262146, 6, -6, 1);               bp_sh[1] = 5'd2; bp_md[1] = 2'b01;
    bp_d[1]  = pout(16'h0001, 16'h0002, 16'hffff, 16'h0000); bp_f[1] = 4'b0000;
    bp_in[2] = pin(-3, 5, 100000, 0);               bp_sh[2] = 5'd1; bp_md[2] = 2'b10;
    bp_d[2]  = pout(16'h0000, 16'h0003, 16'h7fff, 16'h0000); bp_f[2] = 4'b0101;
    bp_in[3] = pin(-10000000, 256, 383, 384);       bp_sh[3] = 5'd8; bp_md[3] = 2'b00;
    bp_d[3]  = pout(16'h8000, 16'h0001, 16'h0001, 16'h0002); bp_f[3] = 4'b0001;
    bp_in[4] = pin(32767, -32768, 32768, -32769);   bp_sh[4] = 5'd0; bp_md[4] = 2'b11;
    bp_d[4]  = pout(16'h7fff, 16'h8000, 16'h7fff, 16'h8000); bp_f[4] = 4'b1100;
    bp_in[5] = pin(-4, -5, 80, 12);                 bp_sh[5] = 5'd3; bp_md[5] = 2'b10;
    bp_d[5]  = pout(16'h0000, 16'h0000, 16'h000a, 16'h0002); bp_f[5] = 4'b0010;

    #12;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("rst_m_valid", 64'(m_valid_out), 64'd0);
    chk("rst_s_ready", 64'(s_ready_out), 64'd1);
    chk("rst_data",    m_data_out, 64'd0);
    chk("rst_flags",   64'(m_sat_flags_out), 64'd0);
    chk("rst_count",   64'(sat_count_out), 64'd0);

    // Latency: valid appears on the third edge counting the accepting edge.
    send(pin(40000, -40000, 1234, -1), 5'd0, 2'b00);
    chk("lat_edge1", 64'(m_valid_out), 64'd0);
    step();
    chk("lat_edge2", 64'(m_valid_out), 64'd0);
    step();
    expect_out("sat", pout(16'h7fff, 16'h8000, 16'h04d2, 16'hffff), 4'b0011, 16'd2);

    send(pin(24, 23, -24, -25), 5'd4, 2'b00); step(); step();
    expect_out("round", pout(16'h0002, 16'h0001, 16'hffff, 16'hfffe), 4'b0000, 16'd2);

    send(pin(32'h7fffffff, 0, 0, 0), 5'd1, 2'b00); step(); step();
    expect_out("maxpos", pout(16'h7fff, 16'h0000, 16'h0000, 16'h0000), 4'b0001, 16'd3);

    send(pin(32'h00018000, 70000, 0, 0), 5'd0, 2'b01); step(); step();
    expect_out("wrap", pout(16'h8000, 16'h1170, 16'h0000, 16'h0000), 4'b0000, 16'd3);

    send(pin(-5, 70000, 0, 100), 5'd0, 2'b10); step(); step();
    expect_out("relu", pout(16'h0000, 16'h7fff, 16'h0000, 16'h0064), 4'b0011, 16'd5);

    send(pin(40000, -40000, 1234, -1), 5'd0, 2'b11); step(); step();
    expect_out("mode3", pout(16'h7fff, 16'h8000, 16'h04d2, 16'hffff), 4'b0011, 16'd7);
    step();

    // Backpressure: 6 streamed beats with a 5-cycle downstream stall.
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 20; c++) begin
      m_ready_in = !(c >= 4 && c <= 8);
      #1;
      if (m_valid_out) begin
        if (rcv < 6) begin
          chk($sformatf("bp%0d_data", rcv), m_data_out, bp_d[rcv]);
          chk($sformatf("bp%0d_flags", rcv), 64'(m_sat_flags_out), 64'(bp_f[rcv]));
          if (m_ready_in) rcv++;
          else chk("bp_stall_s_ready", 64'(s_ready_out), 64'd0);
        end else begin
          chk("bp_extra_beat", 64'(m_valid_out), 64'd0);
        end
      end
      if (sent < 6) begin
        s_data_in  = bp_in[sent];
        s_shift_in = bp_sh[sent];
        s_mode_in  = bp_md[sent];
        s_valid_in = 1'b1;
        if (s_ready_out) sent++;
      end else begin
        s_valid_in = 1'b0;
      end
      step();
    end
    s_valid_in = 1'b0;
    chk("bp_received", 64'(rcv), 64'd6);
    chk("bp_count", 64'(sat_count_out), 64'd14);

    // Reset while three beats are in flight.
    s_data_in = bp_in[0]; s_shift_in = 5'd0; s_mode_in = 2'b00; s_valid_in = 1'b1;
    step(); step(); step();
    s_valid_in = 1'b0;
    m_ready_in = 1'b0;
    chk("mid_pre_valid", 64'(m_valid_out), 64'd1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_valid_out), 64'd0);
    chk("mid_rst_count", 64'(sat_count_out), 64'd0);
    step();
    rst_in = 1'b0;
    m_ready_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_no_stale", 64'(m_valid_out), 64'd0);
    end
    chk("mid_count", 64'(sat_count_out), 64'd0);

    // Counter saturation: 16383 four-flag beats, then 3 more flags reaches the maximum.
    s_data_in = pin(40000, 40000, 40000, 40000); s_shift_in = 5'd0; s_mode_in = 2'b00;
    s_valid_in = 1'b1;
    repeat (16383) @(posedge clk_in);
    #1;
    s_valid_in = 1'b0;
    step(); step(); step();
    chk("cnt_preload", 64'(sat_count_out), 64'd65532);
    send(pin(40000, 40000, 40000, 0), 5'd0, 2'b00); step(); step();
    chk("cnt_reach_max", 64'(sat_count_out), 64'd65535);
    send(pin(40000, 40000, 40000, 40000), 5'd0, 2'b00); step(); step();
    chk("cnt_sticky", 64'(sat_count_out), 64'd65535);
    chk("cnt_sticky_valid", 64'(m_valid_out), 64'd1);

    // Clear on the same edge a flagged beat reaches the output.
    send(pin(40000, 40000, 40000, 40000), 5'd0, 2'b00);
    step();
    sat_count_clear_in = 1'b1;
    step();
    sat_count_clear_in = 1'b0;
    chk("clr_count", 64'(sat_count_out), 64'd0);
    chk("clr_valid", 64'(m_valid_out), 64'd1);
    chk("clr_flags", 64'(m_sat_flags_out), 64'hf);
    send(pin(40000, -40000, 40000, -40000), 5'd0, 2'b00); step(); step();
    chk("clr_resume", 64'(sat_count_out), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
